uart_tx_fifo: RTL and testbench

- Parametrised successor to the single-byte UART transmit engine.
- Adds a programmable baud divider, configurable data width, an optional parity bit and 1 or 2 stop bits.
- A small input FIFO lets software queue several bytes; they are sent back-to-back with no idle gap between frames.
- Sits between the CPU/debug write path and the board TX pin of the emulator.

---
 rtl/uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, a programmable baud divider,
// optional parity and one or two stop bits. Queued bytes are sent back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_BITS-1:0]            data_in,
  input  logic                            transfer_req,
  output logic                            uart_tx,
  output logic                            transfer_ready,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } txState_e;

  txState_e             state_q, state_d;
  logic [BW-1:0]        baudCnt_q, baudCnt_d;
  logic [IW-1:0]        bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 ready_q;
  logic                 busy_q;

  logic                 push;
  logic                 pop;
  logic                 bitDone;
  logic                 fifoNotEmpty;
  logic [DATA_BITS-1:0] head;

  assign push         = transfer_req && ready_q;
  assign fifoNotEmpty = (count_q != '0);
  assign head         = mem_q[rdPtr_q];
  assign bitDone      = (baudCnt_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_d;
      ready_q <= (count_d != FIFO_FULL);
      busy_q  <= (state_d != IDLE) || (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifoNotEmpty) begin
          state_d = START;
        end
      end
      START: begin
        if (bitDone) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bitDone && (bitIdx_q == DATA_LAST)) begin
          state_d = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (bitDone) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bitDone && (bitIdx_q == STOP_LAST)) begin
          state_d = fifoNotEmpty ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    pop       = 1'b0;
    tx_d      = tx_q;
    baudCnt_d = bitDone ? '0 : baudCnt_q + 1'b1;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        baudCnt_d = '0;
        bitIdx_d  = '0;
        tx_d      = 1'b1;
        if (fifoNotEmpty) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = (PARITY == 1) ? ~(^head) : (^head);
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (bitDone) begin
          bitIdx_d = '0;
          tx_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bitDone) begin
          if (bitIdx_q == DATA_LAST) begin
            bitIdx_d = '0;
            tx_d     = (PARITY != 0) ? parity_q : 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            tx_d     = shift_q[1];
            shift_d  = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (bitDone) begin
          bitIdx_d = '0;
          tx_d     = 1'b1;
        end
      end
      STOP: begin
        if (bitDone) begin
          if (bitIdx_q == STOP_LAST) begin
            bitIdx_d = '0;
            if (fifoNotEmpty) begin
              pop      = 1'b1;
              shift_d  = head;
              parity_d = (PARITY == 1) ? ~(^head) : (^head);
              tx_d     = 1'b0;
            end else begin
              tx_d = 1'b1;
            end
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  assign uart_tx        = tx_q;
  assign transfer_ready = ready_q;
  assign busy           = busy_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three configurations (8N1 x1, 8E1 x4, 8O2 x4)
// share one clock; a line monitor rebuilds each frame and compares it to the queue.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] dataD, dataE, dataO;
  logic       reqD, reqE, reqO;
  logic       txD, txE, txO;
  logic       readyD, readyE, readyO;
  logic       busyD, busyE, busyO;
  logic [2:0] cntD, cntE, cntO;

  int checks = 0;
  int errors = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] q2[$];
  int          startsD[$];
  int          negCount = 0;

  bit          monAct[3];
  int          monCyc[3];
  logic [11:0] monGot[3];
  bit          monGlitch[3];

  uart_tx_fifo dutD (
    .clk(clk), .reset(reset), .data_in(dataD), .transfer_req(reqD),
    .uart_tx(txD), .transfer_ready(readyD), .busy(busyD), .fifo_count(cntD)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2)) dutE (
    .clk(clk), .reset(reset), .data_in(dataE), .transfer_req(reqE),
    .uart_tx(txE), .transfer_ready(readyE), .busy(busyE), .fifo_count(cntE)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) dutO (
    .clk(clk), .reset(reset), .data_in(dataO), .transfer_req(reqO),
    .uart_tx(txO), .transfer_ready(readyO), .busy(busyO), .fifo_count(cntO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int inst, input logic req, input logic [7:0] data);
    case (inst)
      0:       begin reqD = req; dataD = data; end
      1:       begin reqE = req; dataE = data; end
      default: begin reqO = req; dataO = data; end
    endcase
  endtask

  task automatic pushExp(input int inst, input logic [11:0] frame);
    case (inst)
      0:       q0.push_back(frame);
      1:       q1.push_back(frame);
      default: q2.push_back(frame);
    endcase
  endtask

  task automatic popExp(input int inst, output bit ok, output logic [11:0] frame);
    ok    = 1'b0;
    frame = '0;
    case (inst)
      0:       if (q0.size() > 0) begin frame = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin frame = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin frame = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int clksOf(input int inst);
    return (inst == 0) ? 1 : 4;
  endfunction

  function automatic int nbitsOf(input int inst);
    return (inst == 0) ? 10 : ((inst == 1) ? 11 : 12);
  endfunction

  function automatic logic busyOf(input int inst);
    return (inst == 0) ? busyD : ((inst == 1) ? busyE : busyO);
  endfunction

  // 8N1 frame in line order: bit 0 is the start bit.
  function automatic logic [11:0] frame8N1(input logic [7:0] b);
    return {2'b00, 1'b1, b, 1'b0};
  endfunction

  task automatic waitIdle(input int inst, input int maxCyc);
    int n;
    n = 0;
    while (busyOf(inst) && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput("idleWithinBound", 32'(busyOf(inst)), 32'd0);
  endtask

  // Line monitor: every bit must hold for its full period.
  initial begin : monitor
    logic [2:0]  s;
    logic [3:0]  bIdx;
    int          ph;
    logic [11:0] expV;
    bit          ok;
    forever begin
      @(negedge clk);
      negCount++;
      s = {txO, txE, txD};
      for (int i = 0; i < 3; i++) begin
        if (!monAct[i] && s[i] == 1'b0) begin
          monAct[i]    = 1'b1;
          monCyc[i]    = 0;
          monGot[i]    = '0;
          monGlitch[i] = 1'b0;
          if (i == 0) startsD.push_back(negCount);
        end
        if (monAct[i]) begin
          bIdx = 4'(monCyc[i] / clksOf(i));
          ph   = monCyc[i] % clksOf(i);
          if (ph == 0) monGot[i][bIdx] = s[i];
          else if (monGot[i][bIdx] !== s[i]) monGlitch[i] = 1'b1;
          monCyc[i]++;
          if (monCyc[i] == nbitsOf(i) * clksOf(i)) begin
            monAct[i] = 1'b0;
            popExp(i, ok, expV);
            checkOutput("frameQueued", 32'(ok), 32'd1);
            if (ok) checkOutput("frameBits", 32'({monGlitch[i], monGot[i]}), 32'(expV));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit sawLow;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);
    applyStimulus(2, 1'b0, 8'h00);
    tick();
    tick();
    reset = 1'b0;

    checkOutput("rstTx", 32'(txD), 32'd1);
    checkOutput("rstReady", 32'(readyD), 32'd1);
    checkOutput("rstBusy", 32'(busyD), 32'd0);
    checkOutput("rstCount", 32'(cntD), 32'd0);
    checkOutput("rstTxE", 32'(txE), 32'd1);
    checkOutput("rstTxO", 32'(txO), 32'd1);

    // 0xDA, 8N1, one cycle per bit
    applyStimulus(0, 1'b1, 8'hDA);
    pushExp(0, 12'h3B4);
    tick();
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("t1CountAfterPush", 32'(cntD), 32'd1);
    checkOutput("t1TxStillIdle", 32'(txD), 32'd1);
    tick();
    checkOutput("t1StartLatency", 32'(txD), 32'd0);
    repeat (9) tick();
    checkOutput("t1BusyInStop", 32'(busyD), 32'd1);
    tick();
    checkOutput("t1BusyFall", 32'(busyD), 32'd0);

    // 0xDA, even parity, four cycles per bit
    applyStimulus(1, 1'b1, 8'hDA);
    pushExp(1, 12'h7B4);
    tick();
    applyStimulus(1, 1'b0, 8'h00);
    repeat (44) tick();
    checkOutput("evenBusyLastCycle", 32'(busyE), 32'd1);
    tick();
    checkOutput("evenBusyFall", 32'(busyE), 32'd0);

    // 0x5E, odd parity, two stop bits
    applyStimulus(2, 1'b1, 8'h5E);
    pushExp(2, 12'hCBC);
    tick();
    applyStimulus(2, 1'b0, 8'h00);
    repeat (48) tick();
    checkOutput("oddBusyLastCycle", 32'(busyO), 32'd1);
    tick();
    checkOutput("oddBusyFall", 32'(busyO), 32'd0);

    // Burst of six requests; the sixth finds the FIFO full
    startsD.delete();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 1'b1, 8'(k));
      if (k <= 5) pushExp(0, frame8N1(8'(k)));
      tick();
      if (k == 5) begin
        checkOutput("burstReadyLow", 32'(readyD), 32'd0);
        checkOutput("burstPeak", 32'(cntD), 32'd4);
      end
    end
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("burstDropCount", 32'(cntD), 32'd4);
    waitIdle(0, 200);
    checkOutput("burstFrames", 32'(startsD.size()), 32'd5);
    for (int i = 1; i < startsD.size(); i++) begin
      checkOutput("burstGapless", 32'(startsD[i] - startsD[i-1]), 32'd10);
    end

    // Full FIFO with a request on the pop edge
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 1'b1, 8'(k * 17));
      pushExp(0, frame8N1(8'(k * 17)));
      tick();
    end
    applyStimulus(0, 1'b0, 8'h00);
    checkOutput("fullCount", 32'(cntD), 32'd4);
    repeat (6) tick();
    applyStimulus(0, 1'b1, 8'hA5);
    tick();
    checkOutput("popEdgeCount", 32'(cntD), 32'd3);
    checkOutput("popEdgeReady", 32'(readyD), 32'd1);
    applyStimulus(0, 1'b1, 8'h3C);
    pushExp(0, frame8N1(8'h3C));
    tick();
    checkOutput("refillCount", 32'(cntD), 32'd4);
    checkOutput("refillReady", 32'(readyD), 32'd0);
    applyStimulus(0, 1'b0, 8'h00);
    waitIdle(0, 200);

    // Reset in the middle of data bit 2 with two bytes queued
    applyStimulus(1, 1'b1, 8'h81);
    tick();
    applyStimulus(1, 1'b1, 8'h42);
    tick();
    applyStimulus(1, 1'b1, 8'h24);
    tick();
    applyStimulus(1, 1'b0, 8'h00);
    checkOutput("abortQueued", 32'(cntE), 32'd2);
    repeat (11) tick();
    checkOutput("abortBit2Low", 32'(txE), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    monAct[1] = 1'b0;
    q1.delete();
    checkOutput("abortTx", 32'(txE), 32'd1);
    checkOutput("abortCount", 32'(cntE), 32'd0);
    checkOutput("abortReady", 32'(readyE), 32'd1);
    checkOutput("abortBusy", 32'(busyE), 32'd0);
    sawLow = 1'b0;
    repeat (60) begin
      tick();
      if (txE == 1'b0) sawLow = 1'b1;
    end
    checkOutput("abortNoFrame", 32'(sawLow), 32'd0);

    repeat (5) tick();
    checkOutput("drainedD", 32'(q0.size()), 32'd0);
    checkOutput("drainedO", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
